// File: rtl/glb_stream_reader_if.sv
// Bundle of the control, RAM read port and output stream signals of
// glb_stream_reader. The master modport is the reader's own view.
interface glb_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR       = 10,
  parameter int LEN_W      = 11
);
  logic                  start;
  logic [ADDR-1:0]       base_addr;
  logic [LEN_W-1:0]      length;
  logic                  busy;
  logic                  done;
  logic                  bram_re;
  logic [ADDR-1:0]       bram_addr;
  logic [DATA_WIDTH-1:0] bram_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_addr, length, bram_rdata, out_ready,
    output busy, done, bram_re, bram_addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, length, bram_rdata, out_ready,
    input  busy, done, bram_re, bram_addr, out_data, out_valid
  );
endinterface

// File: rtl/glb_stream_reader.sv
// Read-side port master for one GLB block RAM port. Fetches length words
// starting at base_addr (wrapping at DEPTH) and streams them through a
// 2-entry FIFO that absorbs the one-cycle RAM read latency and back-pressure.
module glb_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int LEN_W      = $clog2(DEPTH) + 1
) (
  input logic                 clk,
  input logic                 reset,
  glb_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  state_t                state_r;
  state_t                state_next_s;

  logic [LEN_W-1:0]      length_r;
  logic [LEN_W-1:0]      issued_r;
  logic [LEN_W-1:0]      issued_next_s;
  logic [ADDR-1:0]       addr_ptr_r;
  logic [ADDR-1:0]       issue_addr_s;
  logic                  issue_s;

  logic                  busy_r;
  logic                  done_r;
  logic                  bram_re_r;
  logic [ADDR-1:0]       bram_addr_r;

  logic [DATA_WIDTH-1:0] buf_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic                  push_s;
  logic                  pop_s;
  logic [2:0]            occ_s;
  logic                  room_s;

  // Next address with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR-1:0] addr_inc(input logic [ADDR-1:0] a);
    logic [ADDR:0] sum;
    logic [ADDR:0] diff;
    sum  = {1'b0, a} + {{ADDR{1'b0}}, 1'b1};
    diff = sum - DEPTH_W;
    if (sum >= DEPTH_W) begin
      addr_inc = diff[ADDR-1:0];
    end else begin
      addr_inc = sum[ADDR-1:0];
    end
  endfunction

  // A read issued last cycle always lands in the FIFO this cycle.
  assign push_s = bram_re_r;
  assign pop_s  = (count_r != 2'd0) & bus.out_ready;

  // Occupancy after this edge if nothing new is issued; issue only below 2.
  always_comb begin
    occ_s  = {1'b0, count_r} + {2'b00, bram_re_r} - {2'b00, pop_s};
    room_s = (occ_s < 3'd2);
  end

  // Next-state and read-issue decision.
  always_comb begin
    state_next_s  = state_r;
    issue_s       = 1'b0;
    issue_addr_s  = addr_ptr_r;
    issued_next_s = issued_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != {LEN_W{1'b0}}) begin
            state_next_s  = READ;
            issue_s       = 1'b1;
            issue_addr_s  = bus.base_addr;
            issued_next_s = LEN_W'(1'b1);
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (issued_r < length_r) begin
          if (room_s) begin
            issue_s       = 1'b1;
            issued_next_s = issued_r + LEN_W'(1'b1);
            if (issued_next_s == length_r) begin
              state_next_s = DRAIN;
            end else begin
              state_next_s = READ;
            end
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_r == 2'd0) && !bram_re_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered status, RAM port and transfer bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bram_re_r   <= 1'b0;
      bram_addr_r <= {ADDR{1'b0}};
      addr_ptr_r  <= {ADDR{1'b0}};
      issued_r    <= {LEN_W{1'b0}};
      length_r    <= {LEN_W{1'b0}};
    end else begin
      busy_r    <= (state_next_s == READ) || (state_next_s == DRAIN);
      done_r    <= (state_next_s == DONE);
      bram_re_r <= issue_s;
      if (issue_s) begin
        bram_addr_r <= issue_addr_s;
        addr_ptr_r  <= addr_inc(issue_addr_s);
        issued_r    <= issued_next_s;
      end
      if ((state_r == IDLE) && bus.start) begin
        length_r <= bus.length;
      end
    end
  end

  // Two-entry in-order FIFO between RAM read data and the output stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_r[0] <= {DATA_WIDTH{1'b0}};
      buf_r[1] <= {DATA_WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        buf_r[wr_ptr_r] <= bus.bram_rdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.bram_re   = bram_re_r;
  assign bus.bram_addr = bram_addr_r;
  assign bus.out_valid = (count_r != 2'd0);
  assign bus.out_data  = buf_r[rd_ptr_r];

endmodule

// File: tb/tb_glb_stream_reader.sv
// Bench for glb_stream_reader: a table of transfers with a data/address
// scoreboard and a hand-written mid-transfer reset sequence.
module tb_glb_stream_reader;
  localparam int DEPTH = 1000;
  localparam int ADDR  = 10;
  localparam int LEN_W = 11;
  localparam int DW    = 16;

  logic clk;
  logic reset;

  glb_stream_reader_if #(.DATA_WIDTH(DW), .ADDR(ADDR), .LEN_W(LEN_W)) bus();

  glb_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR(ADDR), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [DW-1:0] mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address launched at a rising edge is read on the falling edge.
  always @(negedge clk) begin
    if (bus.bram_re) bus.bram_rdata <= mem[bus.bram_addr];
  end

  typedef struct {
    int base;
    int len;
    int mode;     // 0: ready=1, 1: pattern 1,0,0,1,0,1, 2: random
    int exp;      // expected edges from start acceptance to done, -1 = unchecked
    int restart;  // tick index of a stray start during the transfer, 0 = none
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int failures = 0;
  int issues = 0;
  int pops = 0;
  int ready_mode = 0;
  int ready_idx = 0;
  logic [5:0] ready_pat = 6'b101001;  // bit i is ready at step i
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] data_q[$];
  int addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_ready();
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ready_pat[ready_idx % 6];
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Observes the DUT half a cycle before the edge at which handshakes happen.
  task automatic monitor();
    int a;
    if (bus.bram_re) begin
      issues++;
      check("issue_room", 32'((issues - pops) <= 2), 32'd1);
      if (addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL addr_extra actual=%0d expected=none", bus.bram_addr);
      end else begin
        a = addr_q.pop_front();
        check("bram_addr", 32'(bus.bram_addr), 32'(a));
      end
    end
    if (prev_stall) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data", 32'(bus.out_data), 32'(prev_data));
    end
    if (bus.out_valid && bus.out_ready) begin
      pops++;
      if (data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_extra actual=%0h expected=none", bus.out_data);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(data_q.pop_front()));
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    ready_idx++;
    set_ready();
  endtask

  task automatic run_xfer(input vec_t v);
    int n;
    int a;
    int bound;
    ready_mode = v.mode;
    ready_idx  = 0;
    set_ready();
    for (int i = 0; i < v.len; i++) begin
      a = (v.base + i) % DEPTH;
      addr_q.push_back(a);
      data_q.push_back(mem[a]);
    end
    bus.start     = 1'b1;
    bus.base_addr = ADDR'(v.base);
    bus.length    = LEN_W'(v.len);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'(v.len != 0));
    bound = 4 * v.len + 20;
    n = 0;
    while (!bus.done && n < bound) begin
      if (v.restart != 0 && n == v.restart) begin
        bus.start     = 1'b1;
        bus.base_addr = ADDR'(500);
        bus.length    = LEN_W'(3);
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    if (v.exp >= 0) check("cycles_to_done", 32'(n), 32'(v.exp));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("data_left", 32'(data_q.size()), 32'd0);
    check("addr_left", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    vec_t v6;
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16'h0010);

    vecs[0] = '{0,   4,    0, 6,    0};  // basic stream
    vecs[1] = '{998, 4,    0, 6,    0};  // address wrap at DEPTH
    vecs[2] = '{20,  4,    1, -1,   0};  // back-pressure pattern
    vecs[3] = '{0,   0,    0, 0,    0};  // zero length
    vecs[4] = '{999, 1,    0, 3,    0};  // single word at top address
    vecs[5] = '{10,  6,    0, 8,    2};  // stray start during READ
    vecs[6] = '{995, 10,   2, -1,   0};  // random ready across wrap
    vecs[7] = '{1,   1000, 0, 1002, 0};  // full-depth transfer
    vecs[8] = '{300, 9,    1, -1,   0};  // pattern stall, odd length

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b0;
    bus.bram_rdata = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_bram_re",   32'(bus.bram_re),   32'd0);
    check("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    for (int t = 0; t < 9; t++) run_xfer(vecs[t]);

    // Reset after two of eight words: outputs clear without a clock edge.
    ready_mode = 0;
    ready_idx  = 0;
    set_ready();
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(40 + i);
      data_q.push_back(mem[40 + i]);
    end
    pops = 0;
    issues = 0;
    bus.start     = 1'b1;
    bus.base_addr = ADDR'(40);
    bus.length    = LEN_W'(8);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (pops < 2 && n < 20) begin
      tick();
      n++;
    end
    check("pops_before_reset", 32'(pops), 32'd2);
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    check("mid_rst_done",      32'(bus.done),      32'd0);
    check("mid_rst_bram_re",   32'(bus.bram_re),   32'd0);
    check("mid_rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    data_q.delete();
    addr_q.delete();
    issues = 0;
    pops = 0;
    prev_stall = 1'b0;
    tick();
    tick();
    check("rst_hold_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_done", 32'(bus.done), 32'd0);
    v6 = '{700, 3, 0, 5, 0};
    run_xfer(v6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
